// File: rtl/seqdet_scheduler.sv
// Round-robin scheduler sharing one nine-state run-of-four detector.
// Serializes each granted word LSB-first and reports the match count per requester.
module seqdet_scheduler #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N),
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N*WIDTH-1:0] data,
   output logic [N-1:0]     grant,
   output logic             busy,
   output logic             done,
   output logic [IDW-1:0]   done_id,
   output logic [CW-1:0]    match_count,
   output logic             z,
   output logic [8:0]       det_state
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
   localparam logic [8:0]    DET_A = 9'b000000001;

   state_t             state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]     cur_id_q, cur_id_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]      bitcnt_q, bitcnt_d;
   logic [CW-1:0]      acc_q, acc_d;
   logic [8:0]         det_q, det_d;
   logic [N-1:0]       grant_q, grant_d;
   logic               done_q, done_d;
   logic [IDW-1:0]     done_id_q, done_id_d;
   logic [CW-1:0]      mcount_q, mcount_d;

   logic [IDW-1:0]     win;
   logic               found;
   logic [8:0]         det_nxt;

   // Detector step: zeros walk A/F-I -> B..E, ones walk A/B-E -> F..I.
   function automatic logic [8:0] det_next(input logic [8:0] s,
                                           input logic       w);
      logic [8:0] n;
      n = '0;
      if (!w) begin
         unique case (1'b1)
            s[1]:       n[2] = 1'b1;
            s[2]:       n[3] = 1'b1;
            s[3], s[4]: n[4] = 1'b1;
            default:    n[1] = 1'b1;
         endcase
      end else begin
         unique case (1'b1)
            s[5]:       n[6] = 1'b1;
            s[6]:       n[7] = 1'b1;
            s[7], s[8]: n[8] = 1'b1;
            default:    n[5] = 1'b1;
         endcase
      end
      return n;
   endfunction

   // Round-robin pick: first set request at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            win   = IDW'(idx);
            found = 1'b1;
         end
      end
   end

   // Controller next-state, datapath and registered outputs.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cur_id_d  = cur_id_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      acc_d     = acc_q;
      det_d     = det_q;
      grant_d   = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      mcount_d  = mcount_q;
      det_nxt   = det_next(det_q, shreg_q[0]);
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d[win] = 1'b1;
               cur_id_d     = win;
               rr_ptr_d     = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
               shreg_d      = data[win*WIDTH +: WIDTH];
               bitcnt_d     = '0;
               acc_d        = '0;
               det_d        = DET_A;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            det_d    = det_nxt;
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
            if (det_nxt[4] || det_nxt[8]) acc_d = acc_q + 1'b1;
            if (bitcnt_q == LAST) begin
               state_d   = DONE;
               done_d    = 1'b1;
               done_id_d = cur_id_q;
               mcount_d  = acc_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset; a word in flight is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         cur_id_q  <= '0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         acc_q     <= '0;
         det_q     <= DET_A;
         grant_q   <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         mcount_q  <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         cur_id_q  <= cur_id_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         acc_q     <= acc_d;
         det_q     <= det_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         mcount_q  <= mcount_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign done_id     = done_id_q;
   assign match_count = mcount_q;
   assign det_state   = det_q;
   assign z           = det_q[4] | det_q[8];

endmodule

// File: tb/tb_seqdet_scheduler.sv
// Randomized self-checking bench for seqdet_scheduler.
// Reference: round-robin pointer plus run-length scan of each word.
module tb_seqdet_scheduler;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = $clog2(N);
   localparam int CW    = $clog2(WIDTH + 1);

   logic               clk;
   logic               rst;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] data;
   logic [N-1:0]       grant;
   logic               busy;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic [CW-1:0]      match_count;
   logic               z;
   logic [8:0]         det_state;

   int n_chk  = 0;
   int n_pass = 0;
   int rr     = 0;

   seqdet_scheduler #(.N(N), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data        (data),
      .grant       (grant),
      .busy        (busy),
      .done        (done),
      .done_id     (done_id),
      .match_count (match_count),
      .z           (z),
      .det_state   (det_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_grant"}, 32'(grant), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_done_id"}, 32'(done_id), 0);
      check({tag, "_mcount"}, 32'(match_count), 0);
      check({tag, "_det"}, 32'(det_state), 1);
      check({tag, "_z"}, 32'(z), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rr  = 0;
      check_reset_vals("rst");
   endtask

   // One full service period; req must be nonzero on entry.
   task automatic serve();
      int win, idx, run, cnt;
      logic [WIDTH-1:0] w;
      logic b, prev;
      win = -1;
      for (int i = 0; i < N; i++) begin
         idx = (rr + i) % N;
         if (win < 0 && req[idx]) win = idx;
      end
      if (win < 0) begin
         check("serve_no_req", 32'(req), 1);
         return;
      end
      w = data[win*WIDTH +: WIDTH];
      tick();
      check("grant", 32'(grant), 32'(1) << win);
      check("busy_shift", 32'(busy), 1);
      rr = (win + 1) % N;
      req[win] = 1'b0;
      run  = 0;
      cnt  = 0;
      prev = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         tick();
         b = w[k];
         if (k > 0 && b == prev) run++;
         else run = 1;
         prev = b;
         if (run >= 4) cnt++;
         idx = (run > 4) ? 4 : run;
         if (b) idx = idx + 4;
         check("det_state", 32'(det_state), 32'(1) << idx);
         check("z", 32'(z), (run >= 4) ? 1 : 0);
         if (k < WIDTH - 1) check("done_early", 32'(done), 0);
         if (k < WIDTH - 1) check("grant_off", 32'(grant), 0);
      end
      check("done", 32'(done), 1);
      check("done_id", 32'(done_id), 32'(win));
      check("match_count", 32'(match_count), 32'(cnt));
      tick();
      check("done_pulse", 32'(done), 0);
      check("busy_idle", 32'(busy), 0);
      check("id_hold", 32'(done_id), 32'(win));
   endtask

   initial begin
      logic [N-1:0] r;
      rst  = 1'b0;
      req  = '0;
      data = '0;
      do_reset();

      data[0*WIDTH +: WIDTH] = 8'b11110000;
      data[1*WIDTH +: WIDTH] = 8'h00;
      data[2*WIDTH +: WIDTH] = 8'b01010101;
      data[3*WIDTH +: WIDTH] = 8'hA7;
      req = 4'b0001;
      serve();
      req = 4'b0010;
      serve();
      req = 4'b0100;
      serve();

      do_reset();
      req = 4'b1111;
      for (int i = 0; i < N; i++) serve();

      req = 4'b0100;
      tick();
      check("mw_grant", 32'(grant), 32'b0100);
      req = '0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rr  = 0;
      check_reset_vals("mw");
      for (int i = 0; i < WIDTH + 2; i++) begin
         tick();
         check("mw_no_done", 32'(done), 0);
      end

      req = 4'b0110;
      serve();
      req[2] = 1'b0;

      req = 4'b1000;
      serve();
      req = 4'b1001;
      serve();
      req = 4'b1000;
      serve();

      for (int it = 0; it < 25; it++) begin
         data = {$urandom, $urandom};
         r    = N'($urandom_range(1, (1 << N) - 1));
         req  = r;
         for (int s = 0; s < N && req != '0; s++) serve();
         check("rand_drained", 32'(req), 0);
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check("idle_grant", 32'(grant), 0);
            check("idle_busy", 32'(busy), 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
